// File: rtl/i2c_target_if.sv
// ============================================================================
//  Module      : i2c_target_if
//  Description : Pad-side and FIFO-side signal bundle of the I2C target.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface i2c_target_if;
    logic [6:0] own_address;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_full;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ack;
    logic       busy;
    logic       addr_match;

    modport slave (
        input  own_address, scl_in, sda_in, rx_full, tx_data, tx_valid,
        output sda_oe, rx_data, rx_valid, tx_ack, busy, addr_match
    );

    modport master (
        output own_address, scl_in, sda_in, rx_full, tx_data, tx_valid,
        input  sda_oe, rx_data, rx_valid, tx_ack, busy, addr_match
    );
endinterface

`default_nettype wire

// File: rtl/i2c_target.sv
// ============================================================================
//  Module      : i2c_target
//  Description : I2C target responder - filtered bus sampling, START/STOP
//                detection, 7-bit address match, byte receive and transmit.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_target #(
    parameter int FILT = 3
) (
    input  wire logic     clk,
    input  wire logic     reset,
    i2c_target_if.slave   bus
);

    localparam int                c_CNT_W   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(FILT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_RX_BYTE   = 3'd3;
    localparam logic [2:0] S_RX_ACK    = 3'd4;
    localparam logic [2:0] S_TX_BYTE   = 3'd5;
    localparam logic [2:0] S_TX_CHK    = 3'd6;
    localparam logic [2:0] S_WAIT_STOP = 3'd7;

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {bus.scl_in, bus.sda_in};

    // Index 1 is SCL, index 0 is SDA; both idle high so reset filters to 1.
    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_filt
            logic               r_s1;
            logic               r_s2;
            logic               r_f;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_f   <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[g];
                    r_s2 <= r_s1;
                    if (r_s2 == r_f) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_f   <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign w_filt[g] = r_f;
        end
    endgenerate

    logic w_scl_f;
    logic w_sda_f;
    logic r_scl_prev;
    logic r_sda_prev;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl_f    = w_filt[1];
    assign w_sda_f    = w_filt[0];
    assign w_scl_rise = w_scl_f & ~r_scl_prev;
    assign w_scl_fall = ~w_scl_f & r_scl_prev;
    assign w_start    = w_scl_f & r_sda_prev & ~w_sda_f;
    assign w_stop     = w_scl_f & ~r_sda_prev & w_sda_f;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [7:0] r_rx_sh;
    logic [7:0] w_rx_sh_nxt;
    logic [7:0] r_tx_sh;
    logic [7:0] w_tx_sh_nxt;
    logic       r_pend;
    logic       w_pend_nxt;
    logic       r_rw;
    logic       w_rw_nxt;
    logic       r_sda_oe;
    logic       w_sda_oe_nxt;
    logic [7:0] r_rx_data;
    logic [7:0] w_rx_data_nxt;
    logic       r_rx_valid;
    logic       w_rx_valid_nxt;
    logic       r_tx_ack;
    logic       w_tx_ack_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_addr_match;
    logic       w_addr_match_nxt;

    logic       w_addr_hit;
    logic [7:0] w_tx_byte;

    assign w_addr_hit = (r_rx_sh[7:1] == bus.own_address);
    assign w_tx_byte  = bus.tx_valid ? bus.tx_data : 8'hFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_scl_prev   <= 1'b1;
            r_sda_prev   <= 1'b1;
            r_cnt        <= 3'd0;
            r_rx_sh      <= 8'h00;
            r_tx_sh      <= 8'h00;
            r_pend       <= 1'b0;
            r_rw         <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_tx_ack     <= 1'b0;
            r_busy       <= 1'b0;
            r_addr_match <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_scl_prev   <= w_scl_f;
            r_sda_prev   <= w_sda_f;
            r_cnt        <= w_cnt_nxt;
            r_rx_sh      <= w_rx_sh_nxt;
            r_tx_sh      <= w_tx_sh_nxt;
            r_pend       <= w_pend_nxt;
            r_rw         <= w_rw_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_tx_ack     <= w_tx_ack_nxt;
            r_busy       <= w_busy_nxt;
            r_addr_match <= w_addr_match_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR:     if (w_scl_fall && r_pend)
                                w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_rw ? S_TX_BYTE : S_RX_BYTE;
                S_RX_BYTE:  if (w_scl_fall && r_pend) w_state_nxt = S_RX_ACK;
                S_RX_ACK:   if (w_scl_fall) w_state_nxt = S_RX_BYTE;
                S_TX_BYTE:  if (w_scl_fall && r_cnt == 3'd7) w_state_nxt = S_TX_CHK;
                S_TX_CHK: begin
                    if (w_scl_rise && w_sda_f)
                        w_state_nxt = S_WAIT_STOP;
                    else if (w_scl_fall && r_pend)
                        w_state_nxt = S_TX_BYTE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_rx_sh_nxt      = r_rx_sh;
        w_tx_sh_nxt      = r_tx_sh;
        w_pend_nxt       = r_pend;
        w_rw_nxt         = r_rw;
        w_sda_oe_nxt     = r_sda_oe;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = 1'b0;
        w_tx_ack_nxt     = 1'b0;
        w_busy_nxt       = r_busy;
        w_addr_match_nxt = r_addr_match;

        if (w_stop) begin
            w_sda_oe_nxt     = 1'b0;
            w_busy_nxt       = 1'b0;
            w_addr_match_nxt = 1'b0;
            w_cnt_nxt        = 3'd0;
            w_pend_nxt       = 1'b0;
        end else if (w_start) begin
            w_sda_oe_nxt     = 1'b0;
            w_busy_nxt       = 1'b1;
            w_addr_match_nxt = 1'b0;
            w_cnt_nxt        = 3'd0;
            w_pend_nxt       = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_RX_BYTE: begin
                    if (w_scl_rise) begin
                        w_rx_sh_nxt = {r_rx_sh[6:0], w_sda_f};
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7)
                            w_pend_nxt = 1'b1;
                    end else if (w_scl_fall && r_pend) begin
                        w_pend_nxt = 1'b0;
                        if (r_state == S_ADDR) begin
                            if (w_addr_hit) begin
                                w_sda_oe_nxt = 1'b1;
                                w_rw_nxt     = r_rx_sh[0];
                            end
                        end else if (!bus.rx_full) begin
                            w_rx_valid_nxt = 1'b1;
                            w_rx_data_nxt  = r_rx_sh;
                            w_sda_oe_nxt   = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_addr_match_nxt = 1'b1;
                        w_cnt_nxt        = 3'd0;
                        if (r_rw) begin
                            w_tx_sh_nxt  = w_tx_byte;
                            w_tx_ack_nxt = bus.tx_valid;
                            w_sda_oe_nxt = ~w_tx_byte[7];
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_cnt_nxt    = 3'd0;
                    end
                end
                S_TX_BYTE: begin
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 3'd0;
                        end else begin
                            w_tx_sh_nxt  = {r_tx_sh[6:0], 1'b1};
                            w_sda_oe_nxt = ~r_tx_sh[6];
                            w_cnt_nxt    = r_cnt + 3'd1;
                        end
                    end
                end
                S_TX_CHK: begin
                    // Master ACK arms a reload on the next fall; NACK ends the read.
                    if (w_scl_rise) begin
                        if (w_sda_f)
                            w_sda_oe_nxt = 1'b0;
                        else
                            w_pend_nxt = 1'b1;
                    end else if (w_scl_fall && r_pend) begin
                        w_pend_nxt   = 1'b0;
                        w_cnt_nxt    = 3'd0;
                        w_tx_sh_nxt  = w_tx_byte;
                        w_tx_ack_nxt = bus.tx_valid;
                        w_sda_oe_nxt = ~w_tx_byte[7];
                    end
                end
                S_WAIT_STOP: w_sda_oe_nxt = 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.sda_oe     = r_sda_oe;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.tx_ack     = r_tx_ack;
    assign bus.busy       = r_busy;
    assign bus.addr_match = r_addr_match;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
//  Module      : tb_i2c_target
//  Description : Directed bench - bit-banged I2C master against i2c_target.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target;

    localparam int Q = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    i2c_target_if bus ();

    i2c_target #(.FILT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    logic [7:0] rx_q[$];
    int         tx_ack_n = 0;
    int         oe_n     = 0;
    int         both_n   = 0;

    always @(negedge clk) begin
        if (bus.rx_valid) rx_q.push_back(bus.rx_data);
        if (bus.tx_ack) tx_ack_n++;
        if (bus.sda_oe) oe_n++;
        if (bus.rx_valid && bus.tx_ack) both_n++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = bus.sda_in; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    task automatic test_reset;
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rst_sda_oe: got %b want 0", bus.sda_oe); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_err++; $display("FAIL rst_rx_data: got %h want 00", bus.rx_data); end
        n_cmp++; if (bus.rx_valid !== 1'b0) begin n_err++; $display("FAIL rst_rx_valid: got %b want 0", bus.rx_valid); end
        n_cmp++; if (bus.tx_ack !== 1'b0) begin n_err++; $display("FAIL rst_tx_ack: got %b want 0", bus.tx_ack); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL rst_addr_match: got %b want 0", bus.addr_match); end
    endtask

    task automatic test_write;
        logic a;
        int   rx0 = rx_q.size();
        i2c_start();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wr_busy_start: got %b want 1", bus.busy); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL wr_match_pre: got %b want 0", bus.addr_match); end
        write_byte(8'hA0, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_ack_addr: got %b want 1", a); end
        write_byte(8'h12, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_ack_b0: got %b want 1", a); end
        write_byte(8'h34, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_ack_b1: got %b want 1", a); end
        n_cmp++; if (bus.addr_match !== 1'b1) begin n_err++; $display("FAIL wr_match: got %b want 1", bus.addr_match); end
        i2c_stop();
        tick(Q);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b want 0", bus.busy); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL wr_match_stop: got %b want 0", bus.addr_match); end
        n_cmp++; if (rx_q.size() - rx0 !== 2) begin n_err++; $display("FAIL wr_rx_count: got %0d want 2", rx_q.size() - rx0); end
        else begin
            n_cmp++; if (rx_q[rx0] !== 8'h12) begin n_err++; $display("FAIL wr_rx0: got %h want 12", rx_q[rx0]); end
            n_cmp++; if (rx_q[rx0+1] !== 8'h34) begin n_err++; $display("FAIL wr_rx1: got %h want 34", rx_q[rx0+1]); end
        end
    endtask

    task automatic test_addr_miss;
        logic a;
        int   rx0 = rx_q.size();
        int   oe0 = oe_n;
        i2c_start();
        write_byte(8'hA2, a);
        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL miss_ack_addr: got %b want 0", a); end
        write_byte(8'h55, a);
        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL miss_ack_data: got %b want 0", a); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL miss_match: got %b want 0", bus.addr_match); end
        i2c_stop();
        tick(Q);
        n_cmp++; if (oe_n - oe0 !== 0) begin n_err++; $display("FAIL miss_oe_cycles: got %0d want 0", oe_n - oe0); end
        n_cmp++; if (rx_q.size() - rx0 !== 0) begin n_err++; $display("FAIL miss_rx_count: got %0d want 0", rx_q.size() - rx0); end
    endtask

    task automatic test_read;
        logic       a;
        logic [7:0] d;
        int         tx0 = tx_ack_n;
        bus.tx_data  = 8'hC3;
        bus.tx_valid = 1'b1;
        i2c_start();
        write_byte(8'hA1, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL rd_ack_addr: got %b want 1", a); end
        bus.tx_data = 8'h5A;
        read_byte(d, 1'b0);
        n_cmp++; if (d !== 8'hC3) begin n_err++; $display("FAIL rd_b0: got %h want c3", d); end
        read_byte(d, 1'b1);
        n_cmp++; if (d !== 8'h5A) begin n_err++; $display("FAIL rd_b1: got %h want 5a", d); end
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rd_oe_nack: got %b want 0", bus.sda_oe); end
        n_cmp++; if (tx_ack_n - tx0 !== 2) begin n_err++; $display("FAIL rd_tx_ack: got %0d want 2", tx_ack_n - tx0); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rd_busy_wait: got %b want 1", bus.busy); end
        i2c_stop();
        tick(Q);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rd_busy_stop: got %b want 0", bus.busy); end

        // Empty source: target sends idle 0xFF and must not pop.
        tx0 = tx_ack_n;
        bus.tx_valid = 1'b0;
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(d, 1'b1);
        n_cmp++; if (d !== 8'hFF) begin n_err++; $display("FAIL rd_empty: got %h want ff", d); end
        n_cmp++; if (tx_ack_n - tx0 !== 0) begin n_err++; $display("FAIL rd_empty_ack: got %0d want 0", tx_ack_n - tx0); end
        i2c_stop();
        tick(Q);
    endtask

    task automatic test_rx_full;
        logic a;
        int   rx0 = rx_q.size();
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h11, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL full_ack0: got %b want 1", a); end
        bus.rx_full = 1'b1;
        write_byte(8'h22, a);
        n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL full_ack1: got %b want 0", a); end
        bus.rx_full = 1'b0;
        i2c_stop();
        tick(Q);
        n_cmp++; if (rx_q.size() - rx0 !== 1) begin n_err++; $display("FAIL full_rx_count: got %0d want 1", rx_q.size() - rx0); end
        else begin
            n_cmp++; if (rx_q[rx0] !== 8'h11) begin n_err++; $display("FAIL full_rx0: got %h want 11", rx_q[rx0]); end
        end
    endtask

    task automatic test_repeated_start;
        logic       a;
        logic [7:0] d;
        int         rx0 = rx_q.size();
        int         tx0 = tx_ack_n;
        bus.tx_data  = 8'h96;
        bus.tx_valid = 1'b1;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h01, a);
        i2c_start();
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL sr_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.addr_match !== 1'b0) begin n_err++; $display("FAIL sr_match_clr: got %b want 0", bus.addr_match); end
        write_byte(8'hA1, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL sr_ack_addr: got %b want 1", a); end
        read_byte(d, 1'b1);
        n_cmp++; if (d !== 8'h96) begin n_err++; $display("FAIL sr_rd: got %h want 96", d); end
        n_cmp++; if (bus.addr_match !== 1'b1) begin n_err++; $display("FAIL sr_match: got %b want 1", bus.addr_match); end
        i2c_stop();
        tick(Q);
        n_cmp++; if (tx_ack_n - tx0 !== 1) begin n_err++; $display("FAIL sr_tx_ack: got %0d want 1", tx_ack_n - tx0); end
        n_cmp++; if (rx_q.size() - rx0 !== 1) begin n_err++; $display("FAIL sr_rx_count: got %0d want 1", rx_q.size() - rx0); end
        else begin
            n_cmp++; if (rx_q[rx0] !== 8'h01) begin n_err++; $display("FAIL sr_rx0: got %h want 01", rx_q[rx0]); end
        end
    endtask

    task automatic test_abort_glitch;
        logic a;
        int   rx0 = rx_q.size();
        int   oe0 = oe_n;
        int   tx0;
        i2c_start();
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        i2c_stop();
        tick(Q);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_cmp++; if (oe_n - oe0 !== 0) begin n_err++; $display("FAIL abort_oe: got %0d want 0", oe_n - oe0); end

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        i2c_start();
        write_byte(8'hA1, a);
        n_cmp++; if (bus.sda_oe !== 1'b1) begin n_err++; $display("FAIL rstmid_oe_pre: got %b want 1", bus.sda_oe); end
        tx0   = tx_ack_n;
        reset = 1'b1;
        tick(1);
        n_cmp++; if (bus.sda_oe !== 1'b0) begin n_err++; $display("FAIL rstmid_oe: got %b want 0", bus.sda_oe); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        reset = 1'b0;
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(4 * Q);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_reentry: got %b want 0", bus.busy); end
        n_cmp++; if (tx_ack_n - tx0 !== 0) begin n_err++; $display("FAIL rstmid_tx_ack: got %0d want 0", tx_ack_n - tx0); end

        // Two-cycle SDA dip with SCL high is shorter than the filter.
        sda_m = 1'b0; tick(2);
        sda_m = 1'b1; tick(2 * Q);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL glitch_sda: got %b want 0", bus.busy); end

        // Two-cycle SCL pulse must not shift in an extra address bit.
        rx0 = rx_q.size();
        i2c_start();
        scl_m = 1'b1; tick(2);
        scl_m = 1'b0; tick(Q);
        write_byte(8'hA0, a);
        n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL glitch_scl_ack: got %b want 1", a); end
        write_byte(8'h77, a);
        i2c_stop();
        tick(Q);
        n_cmp++; if (rx_q.size() - rx0 !== 1) begin n_err++; $display("FAIL glitch_rx_count: got %0d want 1", rx_q.size() - rx0); end
        else begin
            n_cmp++; if (rx_q[rx0] !== 8'h77) begin n_err++; $display("FAIL glitch_rx0: got %h want 77", rx_q[rx0]); end
        end
        n_cmp++; if (both_n !== 0) begin n_err++; $display("FAIL rx_tx_overlap: got %0d want 0", both_n); end
    endtask

    initial begin
        bus.own_address = 7'h50;
        bus.rx_full     = 1'b0;
        bus.tx_data     = 8'h00;
        bus.tx_valid    = 1'b0;
        reset = 1'b1;
        tick(4);
        test_reset();
        reset = 1'b0;
        tick(2 * Q);
        test_write();
        test_addr_miss();
        test_read();
        test_rx_full();
        test_repeated_start();
        test_abort_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
